// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller that turns an external 16-bit counter
// into a programmable interval timer. It adds a prescaler, one-shot or
// periodic mode, hold, start/stop, and terminal-event flags.
module counter_ctrl #(
  parameter int unsigned BIT_SZ  = 16,
  parameter int unsigned PRE_SZ  = 8,
  parameter int unsigned WRAP_SZ = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               periodic,
  input  logic [BIT_SZ-1:0]  period,
  input  logic [PRE_SZ-1:0]  prescale,
  input  logic [BIT_SZ-1:0]  count,
  output logic               cnt_enable,
  output logic               cnt_clear,
  output logic               busy,
  output logic               tick,
  output logic               done,
  output logic [WRAP_SZ-1:0] wraps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PRE_SZ-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BIT_SZ-1:0]  period_q, period_d;
  logic [PRE_SZ-1:0]  prescale_q, prescale_d;
  logic               mode_q, mode_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic [WRAP_SZ-1:0] wraps_q, wraps_d;

  logic run_active;
  logic pre_hit;
  logic at_period;
  logic term_evt;
  logic per_term;
  logic one_term;

  // RUN-cycle qualifiers; stop and start take precedence over timing and hold.
  always_comb begin
    run_active = reset && (state_q == S_RUN) && !stop && !start && !hold;
    pre_hit    = run_active && (pre_cnt_q == prescale_q);
    at_period  = (count == period_q);
    term_evt   = pre_hit && at_period;
    per_term   = term_evt && mode_q;
    one_term   = term_evt && !mode_q;
  end

  // State register and all registered datapath values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      wraps_q    <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      wraps_q    <= wraps_d;
    end
  end

  // Next-state logic: stop beats start, start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_RUN;
        S_RUN:   if (one_term) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Counter control and status outputs decoded from the current state.
  always_comb begin
    cnt_enable = pre_hit && !at_period;
    cnt_clear  = !reset || (state_q == S_LOAD) || per_term;
    busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  end

  // Datapath next values: config latch in LOAD, prescaler and wrap count in RUN.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    wraps_d    = wraps_q;
    tick_d     = per_term;
    done_d     = (state_d == S_DONE);
    if (state_q == S_LOAD) begin
      period_d   = period;
      prescale_d = prescale;
      mode_d     = periodic;
      pre_cnt_d  = '0;
      wraps_d    = '0;
    end else if (run_active) begin
      if (pre_hit) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_SZ'(1);
      end
      if (per_term && (wraps_q != '1)) begin
        wraps_d = wraps_q + WRAP_SZ'(1);
      end
    end
  end

  assign tick  = tick_q;
  assign done  = done_q;
  assign wraps = wraps_q;

endmodule
